wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
- Owns the single register-file write port.
- Arbitrates between the in-order pipeline writeback result (P) and a long-latency unit (M, e.g. mul/div or a load returning late).
- M results are buffered in a small FIFO.
- A per-register scoreboard of outstanding M destinations drives the decode-stage hazard outputs.
- Sits between the writeback stage and the register file.

Parameters:
- XLEN, 32, datapath width.
- DEPTH, 2, M result FIFO entries (power of 2, >=2).
- STARVE_LIMIT, 4, cycles a FIFO head may wait before stall_req is raised.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- p_valid  in  1  pipeline writeback valid this cycle (RegWrite qualified).
- p_rd  in  5  pipeline destination register.
- p_data  in  XLEN  pipeline writeback data.
- m_issue  in  1  M operation dispatched this cycle.
- m_issue_rd  in  5  destination of dispatched M op.
- m_valid  in  1  M result offered.
- m_rd  in  5  M result destination.
- m_data  in  XLEN  M result data.
- m_ready  out  1  FIFO can accept M result.
- q_rs1  in  5  decode hazard query.
- q_rs2  in  5  decode hazard query.
- q_rd  in  5  decode hazard query.
- rs1_busy  out  1  q_rs1 has an outstanding M write.
- rs2_busy  out  1  q_rs2 has an outstanding M write.
- rd_busy  out  1  q_rd has an outstanding M write.
- stall_req  out  1  request pipeline to hold p_valid low.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  5  register-file write address.
- rf_wdata  out  XLEN  register-file write data.

Behaviour:
- Reset (rst_n low, async):
  - rf_we=0, rf_waddr=0, rf_wdata=0, stall_req=0.
  - FIFO emptied, so m_ready=1.
  - Scoreboard all 0; starvation counter 0.
  - Effective immediately, including mid-operation; buffered M results are discarded.
- M handshake: a transfer occurs when m_valid && m_ready. m_ready = FIFO not full (registered count, no combinational dependence on m_valid).
- Arbitration, evaluated each cycle:
  - Priority 1: p_valid.
  - Priority 2: FIFO head.
  - Priority 3: a direct M transfer, only when the FIFO is empty (bypass, nothing enqueued).
  - P always wins. If P is granted while an M transfer occurs, the M result is enqueued.
- Latency: the grant is registered. rf_we/rf_waddr/rf_wdata reflect the winner one cycle after the request. rf_we=0 in idle cycles.
- x0: any winner with rd==0 is consumed (dequeued/accepted) but produces rf_we=0. The scoreboard bit for x0 is never set.
- FIFO:
  - Circular buffer with wrapping read/write pointers plus a count.
  - Simultaneous enqueue and dequeue when full is legal: the count is unchanged and m_ready stays 0 that cycle.
  - Underflow is not possible by construction.
- Scoreboard (32 bits):
  - m_issue sets bit[m_issue_rd].
  - An M result winning the port clears bit[rd] in the same edge that loads the output register.
  - Set and clear of the same index in the same cycle: set wins.
- Hazard outputs are combinational from the scoreboard, with no bypass of the same-cycle clear. Query of x0 returns 0.
- Starvation:
  - The counter increments each cycle the FIFO is non-empty and the head loses to P.
  - It resets to 0 when the head is granted or the FIFO is empty.
  - When counter==STARVE_LIMIT, stall_req=1 (registered) and the counter saturates.
  - stall_req stays 1 until the head is granted, then drops the next cycle.
- Pipeline contract: the pipeline drives p_valid=0 while stall_req=1. If p_valid=1 anyway, P still wins and no data is lost.
- Ordering: M results retire in arrival order. A P write and an M write to the same rd are written in grant order. Decode uses rd_busy to prevent this pairing.

Decomposition:
- Shared package `cpu_pkg`:
  - REG_ADDR_W=5 and XLEN.
  - A typedef for the writeback request {valid, rd, data}, reused by the writeback stage.
- One natural sub-module: `wb_result_fifo`, parameterised by DEPTH and XLEN+5 payload width, providing full/empty/count. Arbitration, scoreboard and starvation logic stay in the top module.

Test Plan:
1. Reset mid-traffic: fill the FIFO with 2 entries, set scoreboard bits 5 and 7, pull rst_n low asynchronously -> rf_we=0, m_ready=1, rs1_busy=0 for q_rs1=5, with no clock edge needed.
2. Bypass: FIFO empty, p_valid=0, m_valid=1, m_rd=9, m_data=0xDEADBEEF -> next cycle rf_we=1, rf_waddr=9, rf_wdata=0xDEADBEEF, and bit 9 clears.
3. Collision: p_valid=1, p_rd=3, p_data=0x11 and m_valid=1, m_rd=4, m_data=0x22 in the same cycle, then idle -> writes (3,0x11) then (4,0x22) on consecutive cycles.
4. Full FIFO: hold p_valid=1 with DEPTH=2 while M offers 3 results -> m_ready=0 after 2 enqueues; the third result holds until the FIFO drains, and no result is lost.
5. Starvation: p_valid held 1 with one entry queued -> stall_req=1 after STARVE_LIMIT=4 lost cycles. Drop p_valid -> head written next cycle, then stall_req=0.
6. Scoreboard/x0: m_issue rd=12 and a same-cycle M result clearing rd=12 -> bit 12 stays set. m_issue rd=0 -> rd_busy=0 for q_rd=0. An M result with rd=0 -> rf_we=0 but the FIFO entry is consumed.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-address width, datapath width, the
// writeback request record and small helpers on register indices.
package cpu_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;
  localparam int NUM_REGS   = 32;

  // Writeback request as produced by the writeback stage.
  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

  // True when a write to rd actually changes architectural state (x0 is hardwired).
  function automatic logic rd_writes(input logic [REG_ADDR_W-1:0] rd);
    return (rd != {REG_ADDR_W{1'b0}});
  endfunction

  // One-hot mask for a register index, empty for x0 so its bit never changes.
  function automatic logic [NUM_REGS-1:0] reg_mask(input logic [REG_ADDR_W-1:0] rd);
    logic [NUM_REGS-1:0] mask;
    mask = {NUM_REGS{1'b0}};
    if (rd_writes(rd)) begin
      mask[rd] = 1'b1;
    end else begin
      mask = {NUM_REGS{1'b0}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/wb_result_fifo.sv
// Circular-buffer FIFO holding long-latency results waiting for the
// register-file write port. Wrapping pointers plus an occupancy count.
module wb_result_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 37
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             do_wr_s;
  logic             do_rd_s;

  assign full    = (count_r == CNT_W'(DEPTH));
  assign empty   = (count_r == {CNT_W{1'b0}});
  assign count   = count_r;
  assign rd_data = mem_r[rd_ptr_r];

  // Qualify requests: a write into a full buffer is only legal alongside a read.
  always_comb begin
    do_rd_s = rd_en && !empty;
    do_wr_s = wr_en && (!full || do_rd_s);
  end

  // Storage array; cleared on reset so stale results never reappear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (do_wr_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (do_wr_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (do_rd_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({do_wr_s, do_rd_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Owner of the single register-file write port. The in-order pipeline
// result always wins; long-latency results queue in a small FIFO, retire in
// arrival order, and are tracked by a per-register busy scoreboard that feeds
// the decode-stage hazard checks. A head that keeps losing raises stall_req.
module wb_port_arbiter
  import cpu_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  p_valid,
  input  logic [REG_ADDR_W-1:0] p_rd,
  input  logic [XLEN-1:0]       p_data,
  input  logic                  m_issue,
  input  logic [REG_ADDR_W-1:0] m_issue_rd,
  input  logic                  m_valid,
  input  logic [REG_ADDR_W-1:0] m_rd,
  input  logic [XLEN-1:0]       m_data,
  output logic                  m_ready,
  input  logic [REG_ADDR_W-1:0] q_rs1,
  input  logic [REG_ADDR_W-1:0] q_rs2,
  input  logic [REG_ADDR_W-1:0] q_rd,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  rd_busy,
  output logic                  stall_req,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]       rf_wdata
);

  localparam int PAYLOAD_W = REG_ADDR_W + XLEN;
  localparam int FCNT_W    = $clog2(DEPTH) + 1;
  localparam int STARVE_W  = $clog2(STARVE_LIMIT + 1);

  // FIFO interface
  logic                  fifo_full_s;
  logic                  fifo_empty_s;
  logic [FCNT_W-1:0]     fifo_count_s;
  logic [PAYLOAD_W-1:0]  fifo_head_s;
  logic [REG_ADDR_W-1:0] head_rd_s;
  logic [XLEN-1:0]       head_data_s;
  logic                  head_valid_s;
  logic                  enq_s;
  logic                  deq_s;
  logic                  m_xfer_s;

  // Port winner for this cycle
  logic                  win_valid_s;
  logic                  win_is_m_s;
  logic [REG_ADDR_W-1:0] win_rd_s;
  logic [XLEN-1:0]       win_data_s;

  // Scoreboard and starvation state
  logic [NUM_REGS-1:0]   sb_r;
  logic [NUM_REGS-1:0]   sb_next_s;
  logic [STARVE_W-1:0]   starve_cnt_r;
  logic [STARVE_W-1:0]   starve_cnt_next_s;
  logic                  stall_req_r;

  // Registered write-port outputs
  logic                  rf_we_r;
  logic [REG_ADDR_W-1:0] rf_waddr_r;
  logic [XLEN-1:0]       rf_wdata_r;

  wb_result_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (PAYLOAD_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (enq_s),
    .wr_data ({m_rd, m_data}),
    .rd_en   (deq_s),
    .rd_data (fifo_head_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .count   (fifo_count_s)
  );

  // Acceptance depends only on registered occupancy, never on m_valid.
  assign m_ready      = !fifo_full_s;
  assign m_xfer_s     = m_valid && m_ready;
  assign head_valid_s = (fifo_count_s != {FCNT_W{1'b0}});
  assign head_rd_s    = fifo_head_s[PAYLOAD_W-1:XLEN];
  assign head_data_s  = fifo_head_s[XLEN-1:0];

  // Fixed-priority arbitration: pipeline, then FIFO head, then bypassed M result.
  always_comb begin
    win_valid_s = 1'b0;
    win_is_m_s  = 1'b0;
    win_rd_s    = {REG_ADDR_W{1'b0}};
    win_data_s  = {XLEN{1'b0}};
    enq_s       = 1'b0;
    deq_s       = 1'b0;
    if (p_valid) begin
      win_valid_s = 1'b1;
      win_rd_s    = p_rd;
      win_data_s  = p_data;
      enq_s       = m_xfer_s;
    end else if (head_valid_s) begin
      win_valid_s = 1'b1;
      win_is_m_s  = 1'b1;
      win_rd_s    = head_rd_s;
      win_data_s  = head_data_s;
      deq_s       = 1'b1;
      enq_s       = m_xfer_s;
    end else if (m_xfer_s) begin
      // Empty FIFO: the offered result goes straight to the port, nothing queued.
      win_valid_s = 1'b1;
      win_is_m_s  = 1'b1;
      win_rd_s    = m_rd;
      win_data_s  = m_data;
    end else begin
      win_valid_s = 1'b0;
    end
  end

  // Scoreboard update: retiring M results clear, new issues set; set wins on a tie.
  always_comb begin
    sb_next_s = sb_r;
    if (win_is_m_s) begin
      sb_next_s = sb_next_s & ~reg_mask(win_rd_s);
    end else begin
      sb_next_s = sb_next_s;
    end
    if (m_issue) begin
      sb_next_s = sb_next_s | reg_mask(m_issue_rd);
    end else begin
      sb_next_s = sb_next_s;
    end
  end

  // Starvation count: grows while a queued head loses, saturates at the limit.
  always_comb begin
    starve_cnt_next_s = starve_cnt_r;
    if (fifo_empty_s || deq_s) begin
      starve_cnt_next_s = {STARVE_W{1'b0}};
    end else if (starve_cnt_r != STARVE_W'(STARVE_LIMIT)) begin
      starve_cnt_next_s = starve_cnt_r + STARVE_W'(1);
    end else begin
      starve_cnt_next_s = starve_cnt_r;
    end
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_r <= {NUM_REGS{1'b0}};
    end else begin
      sb_r <= sb_next_s;
    end
  end

  // Starvation counter and the stall request it drives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_r <= {STARVE_W{1'b0}};
      stall_req_r  <= 1'b0;
    end else begin
      starve_cnt_r <= starve_cnt_next_s;
      stall_req_r  <= (starve_cnt_next_s == STARVE_W'(STARVE_LIMIT));
    end
  end

  // Registered grant: the winner reaches the register file one cycle later; x0 is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_r    <= 1'b0;
      rf_waddr_r <= {REG_ADDR_W{1'b0}};
      rf_wdata_r <= {XLEN{1'b0}};
    end else begin
      rf_we_r    <= win_valid_s && rd_writes(win_rd_s);
      rf_waddr_r <= win_rd_s;
      rf_wdata_r <= win_data_s;
    end
  end

  assign rf_we     = rf_we_r;
  assign rf_waddr  = rf_waddr_r;
  assign rf_wdata  = rf_wdata_r;
  assign stall_req = stall_req_r;

  // Hazard lookups read the registered scoreboard only; x0 never reports busy.
  assign rs1_busy = rd_writes(q_rs1) && sb_r[q_rs1];
  assign rs2_busy = rd_writes(q_rs2) && sb_r[q_rs2];
  assign rd_busy  = rd_writes(q_rd)  && sb_r[q_rd];

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: bypass, collision, full FIFO,
// starvation, scoreboard/x0 behaviour and asynchronous reset mid-traffic.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p_valid;
  logic [4:0]  p_rd;
  logic [31:0] p_data;
  logic        m_issue;
  logic [4:0]  m_issue_rd;
  logic        m_valid;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  logic        m_ready;
  logic [4:0]  q_rs1;
  logic [4:0]  q_rs2;
  logic [4:0]  q_rd;
  logic        rs1_busy;
  logic        rs2_busy;
  logic        rd_busy;
  logic        stall_req;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int passed = 0;
  int total  = 0;

  wb_port_arbiter #(.XLEN(32), .DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .p_valid(p_valid), .p_rd(p_rd), .p_data(p_data),
    .m_issue(m_issue), .m_issue_rd(m_issue_rd),
    .m_valid(m_valid), .m_rd(m_rd), .m_data(m_data), .m_ready(m_ready),
    .q_rs1(q_rs1), .q_rs2(q_rs2), .q_rd(q_rd),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .rd_busy(rd_busy),
    .stall_req(stall_req),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_wr(input string tag, input logic we, input logic [4:0] addr, input logic [31:0] data);
    check({tag, ".we"}, {63'd0, rf_we}, {63'd0, we});
    if (we) begin
      check({tag, ".addr"}, {59'd0, rf_waddr}, {59'd0, addr});
      check({tag, ".data"}, {32'd0, rf_wdata}, {32'd0, data});
    end
  endtask

  // Advance one cycle; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    p_valid = 1'b0; p_rd = 5'd0; p_data = 32'd0;
    m_issue = 1'b0; m_issue_rd = 5'd0;
    m_valid = 1'b0; m_rd = 5'd0; m_data = 32'd0;
  endtask

  initial begin
    idle();
    q_rs1 = 5'd0; q_rs2 = 5'd0; q_rd = 5'd0;
    rst_n = 1'b0;
    #12;
    check("reset.we", {63'd0, rf_we}, 64'd0);
    check("reset.waddr", {59'd0, rf_waddr}, 64'd0);
    check("reset.wdata", {32'd0, rf_wdata}, 64'd0);
    check("reset.stall", {63'd0, stall_req}, 64'd0);
    check("reset.m_ready", {63'd0, m_ready}, 64'd1);
    rst_n = 1'b1;
    tick();

    // Bypass: issue to x9, then its result arrives with an empty FIFO.
    m_issue = 1'b1; m_issue_rd = 5'd9;
    tick();
    m_issue = 1'b0; q_rs1 = 5'd9; #1;
    check("bypass.busy_set", {63'd0, rs1_busy}, 64'd1);
    m_valid = 1'b1; m_rd = 5'd9; m_data = 32'hDEADBEEF;
    tick();
    check_wr("bypass", 1'b1, 5'd9, 32'hDEADBEEF);
    idle(); #1;
    check("bypass.busy_clr", {63'd0, rs1_busy}, 64'd0);

    // Collision: P wins, M is queued and follows on the next cycle.
    p_valid = 1'b1; p_rd = 5'd3; p_data = 32'h11;
    m_valid = 1'b1; m_rd = 5'd4; m_data = 32'h22;
    tick();
    check_wr("coll.p", 1'b1, 5'd3, 32'h11);
    idle();
    tick();
    check_wr("coll.m", 1'b1, 5'd4, 32'h22);
    tick();
    check_wr("coll.idle", 1'b0, 5'd0, 32'd0);

    // Full FIFO: P held, three M results offered, the third must wait.
    p_valid = 1'b1; p_rd = 5'd1; p_data = 32'h100;
    m_valid = 1'b1; m_rd = 5'd20; m_data = 32'hA0;
    tick();
    check("full.ready1", {63'd0, m_ready}, 64'd1);
    m_rd = 5'd21; m_data = 32'hA1;
    tick();
    check("full.ready0", {63'd0, m_ready}, 64'd0);
    m_rd = 5'd22; m_data = 32'hA2;
    tick();
    check("full.still0", {63'd0, m_ready}, 64'd0);
    check_wr("full.p", 1'b1, 5'd1, 32'h100);
    p_valid = 1'b0;
    tick();
    check_wr("full.h0", 1'b1, 5'd20, 32'hA0);
    check("full.ready_again", {63'd0, m_ready}, 64'd1);
    tick();
    check_wr("full.h1", 1'b1, 5'd21, 32'hA1);
    m_valid = 1'b0;
    tick();
    check_wr("full.h2", 1'b1, 5'd22, 32'hA2);
    tick();
    check_wr("full.idle", 1'b0, 5'd0, 32'd0);

    // Starvation: one queued entry loses to P for four cycles.
    p_valid = 1'b1; p_rd = 5'd2; p_data = 32'h55;
    m_valid = 1'b1; m_rd = 5'd15; m_data = 32'h77;
    tick();
    m_valid = 1'b0;
    tick(); tick(); tick();
    check("starve.pre", {63'd0, stall_req}, 64'd0);
    tick();
    check("starve.raised", {63'd0, stall_req}, 64'd1);
    tick();
    check("starve.held", {63'd0, stall_req}, 64'd1);
    p_valid = 1'b0;
    tick();
    check_wr("starve.head", 1'b1, 5'd15, 32'h77);
    check("starve.dropped", {63'd0, stall_req}, 64'd0);

    // Scoreboard: same-cycle set and clear of x12, set wins.
    m_issue = 1'b1; m_issue_rd = 5'd12;
    m_valid = 1'b1; m_rd = 5'd12; m_data = 32'hC;
    tick();
    check_wr("sb.write12", 1'b1, 5'd12, 32'hC);
    idle(); q_rd = 5'd12; q_rs2 = 5'd12; #1;
    check("sb.rd_busy12", {63'd0, rd_busy}, 64'd1);
    check("sb.rs2_busy12", {63'd0, rs2_busy}, 64'd1);
    m_issue = 1'b1; m_issue_rd = 5'd0;
    tick();
    m_issue = 1'b0; q_rd = 5'd0; #1;
    check("sb.x0_busy", {63'd0, rd_busy}, 64'd0);

    // x0 result: queued behind P, consumed without a write, next entry follows.
    p_valid = 1'b1; p_rd = 5'd6; p_data = 32'h66;
    m_valid = 1'b1; m_rd = 5'd0; m_data = 32'h99;
    tick();
    m_rd = 5'd8; m_data = 32'h88;
    tick();
    check("x0.full", {63'd0, m_ready}, 64'd0);
    idle();
    tick();
    check_wr("x0.nowrite", 1'b0, 5'd0, 32'd0);
    check("x0.ready", {63'd0, m_ready}, 64'd1);
    tick();
    check_wr("x0.next", 1'b1, 5'd8, 32'h88);
    tick();
    check_wr("x0.idle", 1'b0, 5'd0, 32'd0);

    // Reset mid-traffic: FIFO full, x5/x7 busy, P writing; async reset between edges.
    m_issue = 1'b1; m_issue_rd = 5'd5;
    tick();
    m_issue_rd = 5'd7;
    tick();
    m_issue = 1'b0;
    p_valid = 1'b1; p_rd = 5'd1; p_data = 32'h1;
    m_valid = 1'b1; m_rd = 5'd10; m_data = 32'h10;
    tick();
    m_rd = 5'd11; m_data = 32'h11;
    tick();
    q_rs1 = 5'd5; q_rs2 = 5'd7; #1;
    check("rst.pre_ready", {63'd0, m_ready}, 64'd0);
    check("rst.pre_busy", {63'd0, rs1_busy}, 64'd1);
    check("rst.pre_we", {63'd0, rf_we}, 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst.we", {63'd0, rf_we}, 64'd0);
    check("rst.m_ready", {63'd0, m_ready}, 64'd1);
    check("rst.rs1_busy", {63'd0, rs1_busy}, 64'd0);
    check("rst.rs2_busy", {63'd0, rs2_busy}, 64'd0);
    check("rst.stall", {63'd0, stall_req}, 64'd0);
    idle();
    tick();
    rst_n = 1'b1;
    tick();
    check_wr("rst.after", 1'b0, 5'd0, 32'd0);
    check("rst.after_ready", {63'd0, m_ready}, 64'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
